// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
//   arb_state_t           : arbiter FSM state encoding
//   UART_DATA_W           : width of one UART data byte
//   START_TIMEOUT_DEFAULT : default start-watchdog length in clk cycles
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } arb_state_t;

  localparam int UART_DATA_W           = 8;
  localparam int START_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational rotate-priority encoder. Starting at index ptr and walking
// upward modulo NUM_REQ, it selects the first set bit of req_valid.
//   req_valid : request vector
//   ptr       : highest-priority index for this pick
//   grant     : one-hot winner (all zero when nothing is requested)
//   g         : index of the winner (0 when nothing is requested)
//   any       : at least one request present
module uart_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] g,
  output logic                       any
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;

  // One extra bit on the sum lets ptr+i be reduced modulo NUM_REQ with a
  // single conditional subtract, which also covers non-power-of-two sizes.
  always_comb begin
    grant = '0;
    g     = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!any && req_valid[idx]) begin
        any        = 1'b1;
        g          = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers, with a watchdog for a transmitter that never starts.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   req_valid/req_data: per-requester byte offer (byte i at [8i+7:8i])
//   req_ready         : one-hot accept strobe, combinational, IDLE only
//   uart_din          : registered byte to the transmitter
//   uart_write_enable : transmitter write strobe, held until tx_busy rises
//   uart_tx_busy      : transmitter frame-in-progress flag
//   grant_id          : requester owning the current or last transfer
//   arb_busy          : arbiter is not in IDLE
//   timeout_err       : one-cycle pulse when a start is abandoned
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [UART_DATA_W-1:0]           uart_din,
  output logic                             uart_write_enable,
  input  logic                             uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             arb_busy,
  output logic                             timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  arb_state_t           state, state_nxt;
  logic [GW-1:0]        ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [GW-1:0]        pick_g;
  logic                 pick_any;
  logic                 do_grant;
  logic                 start_timeout;
  logic [UART_DATA_W-1:0] sel_byte;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .g         (pick_g),
    .any       (pick_any)
  );

  // Winner's byte selected through the one-hot grant, so no wide index math.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_byte = sel_byte | (req_data[i*UART_DATA_W +: UART_DATA_W] & {UART_DATA_W{pick_grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by rst_n so no handshake can complete while the
  // arbiter is held in reset. tx_busy outranks the watchdog in START.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    do_grant      = 1'b0;
    start_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && !uart_tx_busy && pick_any) begin
          req_ready = pick_grant;
          do_grant  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (uart_tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          start_timeout = 1'b1;
          state_nxt     = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs follow the next state so they line up with it.
  // An abandoned byte leaves ptr advanced past its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr               <= '0;
      cnt               <= '0;
      uart_din          <= '0;
      uart_write_enable <= 1'b0;
      grant_id          <= '0;
      arb_busy          <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      uart_write_enable <= (state_nxt == START);
      arb_busy          <= (state_nxt != IDLE);
      timeout_err       <= start_timeout;
      if (do_grant) begin
        uart_din <= sel_byte;
        grant_id <= pick_g;
        ptr      <= (pick_g == GW'(NUM_REQ - 1)) ? '0 : pick_g + 1'b1;
        cnt      <= '0;
      end else if (state == START) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, START_TIMEOUT=8) with a
// simple transmitter model that raises busy after a programmable number of
// write_enable cycles and holds it for a programmable frame length.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  uart_din;
  logic        uart_write_enable;
  logic        uart_tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  logic        force_busy;
  logic        m_busy = 1'b0;
  int          m_we_cnt = 0;
  int          m_fcnt = 0;
  int          start_delay;
  int          frame_len;
  logic [7:0]  tx_q[$];

  int rdy_cnt[4] = '{0, 0, 0, 0};
  int spurious = 0;
  int we_cyc = 0;
  int to_cnt = 0;

  int n_chk = 0;
  int n_err = 0;

  assign uart_tx_busy = force_busy | m_busy;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .START_TIMEOUT (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .uart_din          (uart_din),
    .uart_write_enable (uart_write_enable),
    .uart_tx_busy      (uart_tx_busy),
    .grant_id          (grant_id),
    .arb_busy          (arb_busy),
    .timeout_err       (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy rises once write_enable has been seen for
  // start_delay-1 edges (so write_enable is high start_delay cycles);
  // start_delay==0 means the transmitter never starts.
  always @(posedge clk) begin
    if (m_busy) begin
      if (m_fcnt >= frame_len - 1) m_busy <= 1'b0;
      m_fcnt <= m_fcnt + 1;
    end else if (uart_write_enable && start_delay > 0) begin
      if (m_we_cnt + 1 >= start_delay - 1) begin
        m_busy   <= 1'b1;
        m_fcnt   <= 0;
        m_we_cnt <= 0;
        tx_q.push_back(uart_din);
      end else begin
        m_we_cnt <= m_we_cnt + 1;
      end
    end else begin
      m_we_cnt <= 0;
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
      if (req_ready[i] && !req_valid[i]) spurious <= spurious + 1;
    end
    if (uart_write_enable) we_cyc <= we_cyc + 1;
    if (timeout_err) to_cnt <= to_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (k < budget && arb_busy !== 1'b0) begin
      cyc();
      k++;
    end
    chk(tag, 32'(arb_busy), 32'd0);
  endtask

  function automatic int rdy_total();
    return rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
  endfunction

  initial begin
    int n0, r0, k, we0, to0;
    int rs[4];
    rst_n       = 1'b0;
    req_valid   = 4'b0001;
    req_data    = 32'h0;
    force_busy  = 1'b0;
    start_delay = 3;
    frame_len   = 4;

    // Reset state, with a request pending so req_ready gating is exercised.
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    cyc(); cyc();
    chk("rst_din", 32'(uart_din), 32'd0);
    chk("rst_we", 32'(uart_write_enable), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    chk("rst_ready2", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    rst_n = 1'b1;
    cyc();

    // All four requesters valid: order 10,11,12,13,10.
    n0 = tx_q.size();
    r0 = rdy_total();
    for (int i = 0; i < 4; i++) rs[i] = rdy_cnt[i];
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    k = 0;
    while (k < 300 && rdy_total() - r0 < 5) begin
      @(negedge clk);
      k++;
    end
    chk("rr_grant_count", 32'(rdy_total() - r0), 32'd5);
    cyc();
    req_valid = 4'b0000;
    wait_idle("rr_idle", 50);
    chk("rr_byte0", 32'(tx_q[n0]),     32'h10);
    chk("rr_byte1", 32'(tx_q[n0 + 1]), 32'h11);
    chk("rr_byte2", 32'(tx_q[n0 + 2]), 32'h12);
    chk("rr_byte3", 32'(tx_q[n0 + 3]), 32'h13);
    chk("rr_byte4", 32'(tx_q[n0 + 4]), 32'h10);
    chk("rr_rdy0", 32'(rdy_cnt[0] - rs[0]), 32'd2);
    chk("rr_rdy1", 32'(rdy_cnt[1] - rs[1]), 32'd1);
    chk("rr_rdy2", 32'(rdy_cnt[2] - rs[2]), 32'd1);
    chk("rr_rdy3", 32'(rdy_cnt[3] - rs[3]), 32'd1);

    // Single request from requester 2.
    cyc();
    we0 = we_cyc;
    rs[2] = rdy_cnt[2];
    req_data  = 32'h00A50000;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = 4'b0000;
    chk("single_we", 32'(uart_write_enable), 32'd1);
    chk("single_din", 32'(uart_din), 32'hA5);
    chk("single_gid", 32'(grant_id), 32'd2);
    chk("single_ready_off", 32'(req_ready), 32'd0);
    wait_idle("single_idle", 50);
    chk("single_we_width", 32'(we_cyc - we0), 32'd3);
    chk("single_rdy_once", 32'(rdy_cnt[2] - rs[2]), 32'd1);
    chk("single_tx", 32'(tx_q[tx_q.size() - 1]), 32'hA5);
    chk("single_din_hold", 32'(uart_din), 32'hA5);

    // Requester 1 raises then withdraws valid while requester 0 is served.
    cyc();
    we0 = we_cyc;
    for (int i = 0; i < 4; i++) rs[i] = rdy_cnt[i];
    req_data  = 32'h00000055;
    req_valid = 4'b0001;
    #1;
    chk("wd_ready0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0010;
    cyc(); cyc();
    req_valid = 4'b0000;
    wait_idle("wd_idle", 50);
    cyc(); cyc(); cyc();
    chk("wd_rdy1_never", 32'(rdy_cnt[1] - rs[1]), 32'd0);
    chk("wd_rdy0_once", 32'(rdy_cnt[0] - rs[0]), 32'd1);
    chk("wd_we_width", 32'(we_cyc - we0), 32'd3);
    chk("wd_tx", 32'(tx_q[tx_q.size() - 1]), 32'h55);

    // Transmitter busy in IDLE: nothing granted until it falls.
    force_busy = 1'b1;
    cyc();
    req_data  = 32'h00000077;
    req_valid = 4'b0001;
    #1;
    chk("bh_ready_blocked", 32'(req_ready), 32'd0);
    cyc(); cyc();
    chk("bh_ready_blocked2", 32'(req_ready), 32'd0);
    chk("bh_we_low", 32'(uart_write_enable), 32'd0);
    chk("bh_arb_idle", 32'(arb_busy), 32'd0);
    force_busy = 1'b0;
    #1;
    chk("bh_ready_after", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    chk("bh_we", 32'(uart_write_enable), 32'd1);
    chk("bh_gid", 32'(grant_id), 32'd0);
    wait_idle("bh_idle", 50);
    chk("bh_tx", 32'(tx_q[tx_q.size() - 1]), 32'h77);

    // Start timeout: transmitter never starts; requester 1 is next in line.
    cyc();
    start_delay = 0;
    we0 = we_cyc;
    to0 = to_cnt;
    n0  = tx_q.size();
    req_data  = 32'h00009900;
    req_valid = 4'b0010;
    #1;
    chk("to_ready", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = 4'b0000;
    wait_idle("to_idle", 20);
    chk("to_pulse_now", 32'(timeout_err), 32'd1);
    chk("to_we_width", 32'(we_cyc - we0), 32'd8);
    cyc();
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_pulse_once", 32'(to_cnt - to0), 32'd1);
    chk("to_no_frame", 32'(tx_q.size() - n0), 32'd0);
    // ptr now 2: with requesters 0 and 1 valid, search 2,3,0 picks 0.
    start_delay = 3;
    req_data  = 32'h00002211;
    req_valid = 4'b0011;
    #1;
    chk("to_ptr_adv", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    wait_idle("to_idle2", 50);

    // Reset during WAIT_DONE.
    cyc();
    req_data  = 32'h00C30000;
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b0000;
    k = 0;
    while (k < 30 && !(uart_tx_busy === 1'b1 && uart_write_enable === 1'b0 && arb_busy === 1'b1)) begin
      cyc();
      k++;
    end
    chk("mr_in_wait", 32'(uart_tx_busy & arb_busy & ~uart_write_enable), 32'd1);
    chk("mr_din_before", 32'(uart_din), 32'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_din", 32'(uart_din), 32'd0);
    chk("mr_gid", 32'(grant_id), 32'd0);
    chk("mr_busy", 32'(arb_busy), 32'd0);
    chk("mr_we", 32'(uart_write_enable), 32'd0);
    chk("mr_to", 32'(timeout_err), 32'd0);
    cyc(); cyc();
    #2;
    rst_n = 1'b1;
    k = 0;
    while (k < 30 && uart_tx_busy !== 1'b0) begin
      cyc();
      k++;
    end
    chk("mr_frame_end", 32'(uart_tx_busy), 32'd0);
    cyc();
    req_data  = 32'hDD00003C;
    req_valid = 4'b1001;
    #1;
    chk("mr_ptr0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    chk("mr_gid_after", 32'(grant_id), 32'd0);
    chk("mr_we_after", 32'(uart_write_enable), 32'd1);
    chk("mr_din_after", 32'(uart_din), 32'h3C);
    wait_idle("mr_idle", 50);
    chk("no_spurious_ready", 32'(spurious), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
